// File: rtl/muldiv_defs.sv
// Shared op codes, FSM encodings and iteration count for the multiply/divide unit.
// Also used by the decode/control unit, so encodings here are the single source of truth.
package muldiv_defs;

    localparam int ITER  = 32;
    localparam int CNT_W = 6;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // Magnitude of v when treated as signed (sgn=1), otherwise v unchanged.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step on the {remainder, quotient} working register; combinational.
// The shifted partial remainder is 33 bits wide so a 32-bit divisor never overflows it.
module div_step (
    input  logic [63:0] work_in,
    input  logic [31:0] divisor,
    output logic [63:0] work_out
);

    logic [32:0] partial;
    logic [31:0] rem_new;
    logic        fits;

    always_comb begin
        partial = work_in[63:31];
        fits    = (partial >= {1'b0, divisor});
        // When the subtract succeeds the result is below the divisor, so 32 bits suffice.
        rem_new = partial[31:0] - divisor;
        if (fits) begin
            work_out = {rem_new, work_in[30:0], 1'b1};
        end else begin
            work_out = {partial[31:0], work_in[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv32.sv
// Iterative 32x32 multiply / 32/32 divide with HI/LO result registers.
// Result and done 33 edges after start is accepted; start is ignored while busy.
module muldiv32
    import muldiv_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [63:0]      work;
    logic [31:0]      opnd;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             div0;

    logic             is_arith;
    logic             sgn_op;
    logic             a_neg;
    logic             b_neg;
    logic [31:0]      a_mag;
    logic [31:0]      b_mag;
    logic             last;

    logic [32:0]      mul_sum;
    logic [63:0]      mul_nxt;
    logic [63:0]      div_nxt;
    logic [63:0]      prod;
    logic [31:0]      quo;
    logic [31:0]      rem;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;

    div_step u_div_step (
        .work_in  (work),
        .divisor  (opnd),
        .work_out (div_nxt)
    );

    assign is_arith = ~op[2];
    assign sgn_op   = ~op[0];
    assign a_neg    = sgn_op & A[31];
    assign b_neg    = sgn_op & B[31];
    assign a_mag    = mag32(A, sgn_op);
    assign b_mag    = mag32(B, sgn_op);
    assign last     = (cnt == CNT_W'(ITER));

    // Shift-add multiply: the carry out of the upper half shifts into bit 63.
    always_comb begin
        mul_sum = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
        mul_nxt = {mul_sum, work[31:1]};
    end

    always_comb begin
        prod = neg_res ? (~work + 64'd1) : work;
        quo  = neg_res ? (~work[31:0] + 32'd1) : work[31:0];
        rem  = neg_rem ? (~work[63:32] + 32'd1) : work[63:32];
        if (is_div) begin
            res_hi = rem;
            res_lo = div0 ? 32'hFFFF_FFFF : quo;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start && is_arith) state_nxt = ST_RUN;
            ST_RUN:    if (last)              state_nxt = ST_FINISH;
            ST_FINISH:                        state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_FINISH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            work    <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                is_div  <= op[1];
                                neg_res <= a_neg ^ b_neg;
                                neg_rem <= a_neg;
                                div0    <= op[1] && (B == 32'd0);
                                cnt     <= '0;
                                work    <= {32'd0, op[1] ? a_mag : b_mag};
                                opnd    <= op[1] ? b_mag : a_mag;
                            end
                            OP_MTHI: hi <= A;
                            OP_MTLO: lo <= A;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (!last) begin
                        work <= is_div ? div_nxt : mul_nxt;
                        cnt  <= cnt + 1'b1;
                    end else begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv32.md
MULDIV32 -- requirements
Module: muldiv32

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  request strobe; sampled only while busy=0.
REQ-004 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
REQ-005 A  input  32  multiplicand / dividend / MTHI-MTLO source.
REQ-006 B  input  32  multiplier / divisor.
REQ-007 busy  output  1  high while an iterative operation is in progress.
REQ-008 done  output  1  one-cycle pulse when HI/LO receive a MULT/DIV result.
REQ-009 hi  output  32  HI register contents.
REQ-010 lo  output  32  LO register contents.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, FINISH; encodings come from the shared package.
REQ-012 IDLE: start=1 with op in 000..011 SHALL latch operand magnitudes, result-sign flags and op, clear the 6-bit iteration counter, and enter RUN.
REQ-013 IDLE: start=1 with MTHI/MTLO SHALL write A to hi/lo at that edge; no busy, no done.
REQ-014 IDLE: start=1 with op 110/111 SHALL change nothing.
REQ-015 RUN SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for exactly 32 cycles, then enter FINISH.
REQ-016 FINISH SHALL apply sign correction, write hi/lo, assert done for that cycle, and return to IDLE.
REQ-017 busy SHALL be 1 in RUN and FINISH, 0 in IDLE; done SHALL be 1 only in FINISH.
REQ-018 Latency: start accepted at edge E0; hi/lo updated and done=1 after edge E33; busy=0 after edge E34.
REQ-019 start while busy=1 SHALL be ignored, no queuing.
REQ-020 hi/lo SHALL hold their values during RUN; they change only at the FINISH edge or on MTHI/MTLO.
REQ-021 MULT/MULTU: {hi,lo} = full 64-bit product; signed is formed by magnitude multiply plus two's-complement negate when operand signs differ.
REQ-022 DIV/DIVU: lo = quotient, hi = remainder; signed quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-023 Divide by zero (either signedness): lo = 32'hFFFFFFFF, hi = A; full latency still applies.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0, no trap.
REQ-025 Operands SHALL be captured at E0; changes to A/B/op after E0 have no effect.

Reset
REQ-026 reset=1 SHALL force state IDLE, busy=0, done=0, hi=0, lo=0, counter=0 at the next edge, including mid-operation (the result is discarded).
REQ-027 reset SHALL take priority over start in the same cycle.

Structure
REQ-028 Op codes, FSM state encodings and the iteration count (32) SHALL reside in the shared package muldiv_defs, shared with the decode/control unit.
REQ-029 The iterative divide step SHALL be one sub-module, div_step (one restoring step, combinational); the multiply step SHALL stay inline.
REQ-030 Design size SHALL be 120-400 lines of RTL; one 64-bit working register is shared between multiply and divide.

Verification
REQ-031 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001; done exactly 33 edges after E0.
REQ-032 MULT A=0xFFFFFFFD (-3) B=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1.
REQ-033 DIV A=0xFFFFFFF9 (-7) B=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-034 DIVU A=100 B=0 -> lo=0xFFFFFFFF hi=0x00000064.
REQ-035 MTHI A=0x12345678 while idle -> hi updated the next edge, no done; second start with op=MULTU at cycle 5 of a DIVU run -> ignored; the DIVU result is unchanged.
REQ-036 reset asserted at cycle 10 of MULT -> next edge busy=0, done=0, hi=lo=0; no done pulse follows.
